// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared states, frame constants and default timing for PS/2 host TX
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INHIBIT    = 3'd1,
        REQ        = 3'd2,
        WAIT_FIRST = 3'd3,
        XFER       = 3'd4,
        WAIT_IDLE  = 3'd5,
        ERR        = 3'd6
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int ACK_EDGE   = 11;

    localparam int DEF_INHIBIT_CYC    = 12000;
    localparam int DEF_FIRST_EDGE_CYC = 1500000;
    localparam int DEF_FRAME_CYC      = 200000;
    localparam int DEF_TMR_W          = 21;

    // Bits shifted out after the start bit: data LSB first, odd parity, stop.
    function automatic logic [FRAME_BITS-2:0] build_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_host_if
// Brief    : Request/status handshake plus open-drain pin pair of the host TX
// Revision : 1.0
// ============================================================================
interface ps2_host_if;

    logic       send;
    logic [7:0] data;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic       ack_ok;
    logic       error;
    logic       ps2clk_in;
    logic       ps2data_in;
    logic       ps2clk_oe;
    logic       ps2data_oe;

    modport master (
        output send, data, ps2clk_in, ps2data_in,
        input  busy, rx_inhibit, done, ack_ok, error, ps2clk_oe, ps2data_oe
    );

    modport slave (
        input  send, data, ps2clk_in, ps2data_in,
        output busy, rx_inhibit, done, ack_ok, error, ps2clk_oe, ps2data_oe
    );

endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_line_sync
// Brief    : PS/2 pin synchronizers, 4-sample clock filter and fall detect
// Revision : 1.0
// ============================================================================
module ps2_line_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic ps2clk_i,
    input  wire logic ps2data_i,
    output logic      clk_filt_o,
    output logic      data_sync_o,
    output logic      fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic [3:0] clk_hist_q;
    logic       clk_filt_q;
    logic       clk_filt_prev_q;

    // Idle bus is high, so everything resets to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q      <= 2'b11;
            data_sync_q     <= 2'b11;
            clk_hist_q      <= 4'hF;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q      <= {clk_sync_q[0], ps2clk_i};
            data_sync_q     <= {data_sync_q[0], ps2data_i};
            clk_hist_q      <= {clk_hist_q[2:0], clk_sync_q[1]};
            clk_filt_prev_q <= clk_filt_q;
            if (&clk_hist_q) begin
                clk_filt_q <= 1'b1;
            end else if (~|clk_hist_q) begin
                clk_filt_q <= 1'b0;
            end
        end
    end

    assign clk_filt_o  = clk_filt_q;
    assign data_sync_o = data_sync_q[1];
    assign fall_o      = clk_filt_prev_q & ~clk_filt_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter with ack and timeouts
// Revision : 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC    = DEF_INHIBIT_CYC,
    parameter int FIRST_EDGE_CYC = DEF_FIRST_EDGE_CYC,
    parameter int FRAME_CYC      = DEF_FRAME_CYC,
    parameter int TMR_W          = DEF_TMR_W
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    ps2_host_if.slave  bus
);

    localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0] FIRST_LIMIT  = TMR_W'(FIRST_EDGE_CYC);
    localparam logic [TMR_W-1:0] FRAME_LIMIT  = TMR_W'(FRAME_CYC);
    localparam logic [3:0]       LAST_BIT     = 4'(ACK_EDGE - 1);

    ps2_state_t              state_q;
    logic [FRAME_BITS-2:0]   shreg_q;
    logic [3:0]              bitcnt_q;
    logic [TMR_W-1:0]        timer_q;
    logic [TMR_W-1:0]        timer_d;
    logic                    clk_oe_q;
    logic                    data_oe_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    ack_ok_q;
    logic                    ack_r_q;
    logic                    error_q;

    logic                    clk_filt;
    logic                    data_sync;
    logic                    fall;

    ps2_line_sync u_line_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2clk_i    (bus.ps2clk_in),
        .ps2data_i   (bus.ps2data_in),
        .clk_filt_o  (clk_filt),
        .data_sync_o (data_sync),
        .fall_o      (fall)
    );

    assign timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= 4'd0;
            timer_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            ack_r_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q    <= 1'b0;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (bus.send) begin
                        shreg_q  <= build_frame(bus.data);
                        bitcnt_q <= 4'd0;
                        timer_q  <= '0;
                        busy_q   <= 1'b1;
                        clk_oe_q <= 1'b1;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    timer_q <= timer_d;
                    if (timer_q >= INHIBIT_LAST) begin
                        data_oe_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Release clock while still holding the start bit low.
                    clk_oe_q <= 1'b0;
                    timer_q  <= '0;
                    state_q  <= WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (fall) begin
                        bitcnt_q  <= 4'd1;
                        data_oe_q <= ~shreg_q[0];
                        timer_q   <= '0;
                        state_q   <= XFER;
                    end else if (timer_q >= FIRST_LIMIT) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                XFER: begin
                    if (timer_q >= FRAME_LIMIT) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= ERR;
                    end else begin
                        timer_q <= timer_d;
                        if (fall) begin
                            if (bitcnt_q == LAST_BIT) begin
                                ack_r_q   <= ~data_sync;
                                data_oe_q <= 1'b0;
                                state_q   <= WAIT_IDLE;
                            end else begin
                                bitcnt_q  <= bitcnt_q + 4'd1;
                                shreg_q   <= {1'b1, shreg_q[FRAME_BITS-2:1]};
                                data_oe_q <= ~shreg_q[1];
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (timer_q >= FRAME_LIMIT) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= ERR;
                    end else if (clk_filt && data_sync) begin
                        done_q   <= 1'b1;
                        ack_ok_q <= ack_r_q;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                ERR: begin
                    busy_q    <= 1'b0;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ps2clk_oe  = clk_oe_q;
    assign bus.ps2data_oe = data_oe_q;
    assign bus.busy       = busy_q;
    assign bus.rx_inhibit = busy_q;
    assign bus.done       = done_q;
    assign bus.ack_ok     = ack_ok_q;
    assign bus.error      = error_q;

endmodule
`default_nettype wire
